inst_fetch: RTL



---
 rtl/inst_fetch_pkg.sv | 42 ++++
 rtl/inst_fetch_if_buf.sv | 76 +++++++
 rtl/inst_fetch.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
//   Shared constants for the instruction-fetch stage: bus widths, the NOP
//   word, stall/reset polarities, and the fetch FSM state encodings.
//   Also holds the PC helpers shared by the FSM.
//
//   Optional feature macro: IF_ALIGN_CHECK_EN
//     defined   -> redirect targets keep their low bits so that misaligned
//                  targets can be reported as address errors
//     undefined -> redirect targets are forced to word alignment
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0]     ZeroInst     = '0;
  localparam logic [InstAddrBus-1:0] ZeroInstAddr = '0;

  localparam logic StallNo   = 1'b0;
  localparam logic RstEnable = 1'b1;

  localparam logic [1:0] IF_IDLE  = 2'd0;
  localparam logic [1:0] IF_BUSY  = 2'd1;
  localparam logic [1:0] IF_FULL  = 2'd2;
  localparam logic [1:0] IF_DRAIN = 2'd3;

  // Sequential PC; wraps silently from 0xFFFF_FFFC to 0.
  function automatic logic [InstAddrBus-1:0] pc_inc(input logic [InstAddrBus-1:0] pc);
    return pc + 32'd4;
  endfunction

  // Target address as used for a flush or branch redirect.
  function automatic logic [InstAddrBus-1:0] redirect_addr(input logic [InstAddrBus-1:0] t);
`ifdef IF_ALIGN_CHECK_EN
    return t;
`else
    return {t[InstAddrBus-1:2], 2'b00};
`endif
  endfunction

endpackage

// File: rtl/inst_fetch_if_buf.sv
// -----------------------------------------------------------------------------
// if_buf
//   One-entry buffer {pc, inst, adel, valid} that presents the fetched
//   instruction to the IF/ID register.
//   Control priority: load > clear > consume.
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     load              capture load_pc/load_inst/load_adel, mark valid
//     clear             drop the entry (flush)
//     consume           entry taken by IF/ID, drop it unless reloaded
//     load_pc/inst/adel data written on load
//     pc, inst, adel    presented entry (inst is NOP, adel is 0 when empty)
//     valid             entry holds a real instruction or error marker
// -----------------------------------------------------------------------------
module if_buf
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = ZeroInstAddr
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   clear,
  input  logic                   consume,
  input  logic [InstAddrBus-1:0] load_pc,
  input  logic [InstBus-1:0]     load_inst,
  input  logic                   load_adel,
  output logic [InstAddrBus-1:0] pc,
  output logic [InstBus-1:0]     inst,
  output logic                   adel,
  output logic                   valid
);

  logic [InstAddrBus-1:0] pc_q,   pc_d;
  logic [InstBus-1:0]     inst_q, inst_d;
  logic                   adel_q, adel_d;
  logic                   valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    adel_d  = adel_q;
    valid_d = valid_q;
    if (load) begin
      pc_d    = load_pc;
      inst_d  = load_inst;
      adel_d  = load_adel;
      valid_d = 1'b1;
    end else if (clear || consume) begin
      // pc is kept so if_pc stays stable while the buffer is empty
      valid_d = 1'b0;
      adel_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc_q    <= RESET_PC;
      inst_q  <= ZeroInst;
      adel_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      adel_q  <= adel_d;
      valid_q <= valid_d;
    end
  end

  assign pc    = pc_q;
  assign inst  = valid_q ? inst_q : ZeroInst;
  assign adel  = valid_q & adel_q;
  assign valid = valid_q;

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   MIPS instruction-fetch stage. Owns the fetch PC, runs the req/ack
//   handshake with instruction memory and presents one instruction to IF/ID.
//   Handles stalls, exception flushes and branches with one delay slot.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     stall                    ctrl stall; StallNo means IF/ID captures
//     flush, flush_pc          exception flush pulse and its target
//     branch_flag, branch_target  taken branch from ID and its target
//     mem_req, mem_addr        fetch request (stable until mem_ack)
//     mem_ack, mem_rdata       fetch response (single-cycle ack)
//     if_pc, if_inst           presented instruction (NOP when invalid)
//     if_valid                 presented instruction is real
//     if_adel                  presented entry is an address-error marker
//
//   Optional feature macro: IF_ALIGN_CHECK_EN (misaligned redirect targets
//   produce an address-error entry instead of a fetch).
// -----------------------------------------------------------------------------
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = ZeroInstAddr
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [InstAddrBus-1:0] flush_pc,
  input  logic                   branch_flag,
  input  logic [InstAddrBus-1:0] branch_target,
  output logic                   mem_req,
  output logic [InstAddrBus-1:0] mem_addr,
  input  logic                   mem_ack,
  input  logic [InstBus-1:0]     mem_rdata,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst,
  output logic                   if_valid,
  output logic                   if_adel
);

  logic [1:0]             state_q,       state_d;
  logic [InstAddrBus-1:0] req_addr_q,    req_addr_d;
  logic [InstAddrBus-1:0] fetch_pc_q,    fetch_pc_d;
  logic                   pend_q,        pend_d;
  logic [InstAddrBus-1:0] pend_target_q, pend_target_d;

  logic                   buf_load, buf_clear;
  logic [InstAddrBus-1:0] ld_pc;
  logic [InstBus-1:0]     ld_inst;
  logic                   ld_adel;
  logic [InstAddrBus-1:0] buf_pc;
  logic [InstBus-1:0]     buf_inst;
  logic                   buf_adel, buf_valid;

  logic                   consume, br_now, full_req, req_int, ack_hit;
  logic [InstAddrBus-1:0] br_tgt;
  logic                   go;
  logic [InstAddrBus-1:0] go_tgt;

  // An error marker is never a delay slot; it just parks the stage in IDLE.
  assign consume  = buf_valid & (stall == StallNo);
  assign br_now   = consume & ~buf_adel & ~flush & (pend_q | branch_flag);
  assign br_tgt   = pend_q ? pend_target_q : redirect_addr(branch_target);
  // FULL issues the next sequential fetch only in the cycle the entry leaves.
  assign full_req = (state_q == IF_FULL) & consume & ~buf_adel & ~br_now & ~flush;
  assign req_int  = (state_q == IF_BUSY) | (state_q == IF_DRAIN) | full_req;
  assign ack_hit  = req_int & mem_ack;

  assign mem_req  = req_int & (rst != RstEnable);
  assign mem_addr = full_req ? fetch_pc_q : req_addr_q;

  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    fetch_pc_d    = fetch_pc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    ld_pc         = req_addr_q;
    ld_inst       = mem_rdata;
    ld_adel       = 1'b0;
    go            = 1'b0;
    go_tgt        = fetch_pc_q;

    case (state_q)
      IF_BUSY: begin
        if (ack_hit) begin
          buf_load   = 1'b1;
          fetch_pc_d = pc_inc(req_addr_q);
          state_d    = IF_FULL;
        end
      end
      IF_FULL: begin
        if (consume) begin
          if (buf_adel) begin
            state_d = IF_IDLE;
          end else if (br_now) begin
            // delay slot leaves now; slot+4 is never requested
            go     = 1'b1;
            go_tgt = br_tgt;
          end else if (ack_hit) begin
            buf_load   = 1'b1;
            ld_pc      = fetch_pc_q;
            fetch_pc_d = pc_inc(fetch_pc_q);
          end else begin
            state_d    = IF_BUSY;
            req_addr_d = fetch_pc_q;
          end
        end
      end
      IF_DRAIN: begin
        // stale response is dropped; fetch_pc already holds the new target
        if (ack_hit) begin
          go     = 1'b1;
          go_tgt = fetch_pc_q;
        end
      end
      default: ;
    endcase

    if (br_now) begin
      pend_d = 1'b0;
    end else if (branch_flag) begin
      pend_d        = 1'b1;
      pend_target_d = redirect_addr(branch_target);
    end

    // flush overrides everything above, including any ack this cycle
    if (flush) begin
      buf_load  = 1'b0;
      buf_clear = 1'b1;
      pend_d    = 1'b0;
      if (req_int && !mem_ack) begin
        state_d    = IF_DRAIN;
        fetch_pc_d = redirect_addr(flush_pc);
        go         = 1'b0;
      end else begin
        go     = 1'b1;
        go_tgt = redirect_addr(flush_pc);
      end
    end

    if (go) begin
      fetch_pc_d = go_tgt;
`ifdef IF_ALIGN_CHECK_EN
      if (go_tgt[1:0] != 2'b00) begin
        state_d  = IF_FULL;
        buf_load = 1'b1;
        ld_pc    = go_tgt;
        ld_inst  = ZeroInst;
        ld_adel  = 1'b1;
      end else begin
        state_d    = IF_BUSY;
        req_addr_d = go_tgt;
      end
`else
      state_d    = IF_BUSY;
      req_addr_d = go_tgt;
`endif
    end
  end

  // Reset lands in BUSY so the first post-reset cycle already requests RESET_PC.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q       <= IF_BUSY;
      req_addr_q    <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      pend_q        <= 1'b0;
      pend_target_q <= RESET_PC;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      fetch_pc_q    <= fetch_pc_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
    end
  end

  if_buf #(
    .RESET_PC (RESET_PC)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .clear     (buf_clear),
    .consume   (consume),
    .load_pc   (ld_pc),
    .load_inst (ld_inst),
    .load_adel (ld_adel),
    .pc        (buf_pc),
    .inst      (buf_inst),
    .adel      (buf_adel),
    .valid     (buf_valid)
  );

  assign if_pc    = buf_pc;
  assign if_inst  = buf_inst;
  assign if_valid = buf_valid;
`ifdef IF_ALIGN_CHECK_EN
  assign if_adel  = buf_adel;
`else
  assign if_adel  = 1'b0;
`endif

endmodule
